// File: rtl/or_d.sv
// Registered bitwise-OR ALU slice with a valid/ready output stage and
// zero / all-ones / odd-parity status flags.
module or_d #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] out_q,    out_d;
  logic             zero_q,   zero_d;
  logic             ones_q,   ones_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] result_c;
  logic             accept_c;

  // The stage frees up whenever it is empty or its result leaves this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept_c = in_valid && in_ready;
  assign result_c = ina | inb;

  always_comb begin
    valid_d  = valid_q;
    out_d    = out_q;
    zero_d   = zero_q;
    ones_d   = ones_q;
    parity_d = parity_q;
    if (accept_c) begin
      valid_d  = 1'b1;
      out_d    = result_c;
      zero_d   = (result_c == '0);
      ones_d   = &result_c;
      parity_d = ^result_c;
    end else if (out_ready) begin
      // Drain: result and flags keep their last values.
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      out_q    <= '0;
      zero_q   <= 1'b1;
      ones_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      ones_q   <= ones_d;
      parity_q <= parity_d;
    end
  end

  assign out_valid = valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign parity    = parity_q;

endmodule

// File: tb/tb_or_d.sv
// Self-checking bench for or_d: directed test-plan steps plus random traffic,
// compared against a transaction-level model of the output stage.
module tb_or_d;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] ina = '0;
  logic [WIDTH-1:0] inb = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             ones;
  logic             parity;

  int n_cmp = 0;
  int n_err = 0;

  // Model: the single result slot (occupied flag + held value).
  bit               m_full = 1'b0;
  logic [WIDTH-1:0] m_val  = '0;

  or_d #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ina      (ina),
    .inb      (inb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .zero     (zero),
    .ones     (ones),
    .parity   (parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's slot.
  task automatic chk_all(input string tag);
    logic [63:0] all1;
    all1 = (64'd1 << WIDTH) - 64'd1;
    chk({tag, ".out"},       64'(out),       64'(m_val));
    chk({tag, ".zero"},      64'(zero),      64'(m_val == '0));
    chk({tag, ".ones"},      64'(ones),      64'(64'(m_val) == all1));
    chk({tag, ".parity"},    64'(parity),    64'($countones(m_val) % 2));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_full));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(!m_full || out_ready));
  endtask

  // One clock: drive inputs, check ready before the edge, advance model, check after.
  task automatic step(input string tag, input bit v, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input bit ordy);
    bit can_take;
    in_valid  = v;
    ina       = a;
    inb       = b;
    out_ready = ordy;
    #1;
    can_take = !m_full || ordy;
    chk({tag, ".pre_ready"}, 64'(in_ready), 64'(can_take));
    @(posedge clk);
    if (v && can_take) begin
      m_full = 1'b1;
      m_val  = a | b;
    end else if (ordy) begin
      m_full = 1'b0;
    end
    #1;
    chk_all(tag);
  endtask

  // Async reset asserted between edges; checked before any clock edge occurs.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    m_full = 1'b0;
    m_val  = '0;
    #1;
    chk_all({tag, ".imm"});
    @(posedge clk);
    #1;
    chk_all({tag, ".held"});
    #2;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    async_reset("rst0");
    chk("rst0.zero_const", 64'(zero), 64'd1);

    // Back-to-back ORs with out_ready held high.
    step("b0", 1, 8'hD4, 8'hE3, 1);
    chk("b0.const", 64'({out, zero, ones, parity}), 64'({8'hF7, 3'b001}));
    step("b1", 1, 8'hFF, 8'hDA, 1);
    chk("b1.const", 64'({out, ones, parity}), 64'({8'hFF, 2'b10}));
    step("b2", 1, 8'hD4, 8'h00, 1);
    chk("b2.const", 64'({out, parity}), 64'({8'hD4, 1'b0}));
    step("b3", 1, 8'hD4, 8'h23, 1);
    chk("b3.const", 64'({out, parity, out_valid}), 64'({8'hF7, 2'b11}));
    step("z0", 1, 8'h00, 8'h00, 1);
    chk("z0.const", 64'({out, zero, ones, parity}), 64'({8'h00, 3'b100}));

    // Backpressure: result held while the new pair is refused.
    step("bp0", 1, 8'hD4, 8'hE3, 1);
    for (int i = 0; i < 3; i++) begin
      step("bp_stall", 1, 8'h00, 8'h01, 0);
      chk("bp_stall.const", 64'({out, out_valid, in_ready}), 64'({8'hF7, 2'b10}));
    end
    step("bp_rel", 1, 8'h00, 8'h01, 1);
    chk("bp_rel.const", 64'(out), 64'h01);

    // Drain without refill keeps the last value.
    step("dr0", 0, 8'hAA, 8'h55, 1);
    chk("dr0.const", 64'({out, out_valid}), 64'({8'h01, 1'b0}));
    step("dr1", 0, 8'h00, 8'h00, 1);

    // Reset while stalled discards the pending result.
    step("rs0", 1, 8'h12, 8'h30, 1);
    step("rs1", 0, 8'h00, 8'h00, 0);
    async_reset("rst1");
    chk("rst1.const", 64'({out, out_valid, in_ready}), 64'({8'h00, 2'b01}));
    step("ra0", 1, 8'hFF, 8'hDA, 1);
    chk("ra0.const", 64'({out, ones}), 64'({8'hFF, 1'b1}));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom & $urandom),
           1'($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
